// File: rtl/rv_mem_pkg.sv
// Shared constants and request record for the program/data RAM port arbiter.
package rv_mem_pkg;

    localparam int unsigned MEM_DEPTH = 2048;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned M_IFETCH  = 0;
    localparam int unsigned M_LSU     = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the requester equal to prio wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       contended
);

    assign contended = req[0] & req[1];
    assign gnt[0]    = req[0] & (~req[1] | ~prio);
    assign gnt[1]    = req[1] & (~req[0] |  prio);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a 1W/1R registered-read RAM between instruction fetch (0) and the LSU (1);
// illegal accesses are accepted and answered with an error, never reaching the RAM.
module ram_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = rv_mem_pkg::MEM_DEPTH,
    parameter int unsigned ADDR_W    = rv_mem_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             m_req,
    input  logic [1:0]             m_we,
    input  logic [1:0][31:0]       m_addr,
    input  logic [1:0][31:0]       m_wdata,
    output logic [1:0]             m_gnt,
    output logic [1:0]             m_rvalid,
    output logic [1:0]             m_err,
    output logic [1:0][31:0]       m_rdata,
    output logic                   ram_wen,
    output logic [ADDR_W-1:0]      ram_waddr,
    output logic [31:0]            ram_wdata,
    output logic                   ram_ren,
    output logic [ADDR_W-1:0]      ram_raddr,
    input  logic [31:0]            ram_rdata
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    mem_req_t          w_req [2];
    logic [ADDR_W-1:0] w_idx [2];
    logic [1:0]        w_legal;
    logic [1:0]        w_rd_req;
    logic [1:0]        w_wr_req;
    logic [1:0]        w_rd_pick_req;
    logic [1:0]        w_wr_pick_req;
    logic [1:0]        w_rd_gnt;
    logic [1:0]        w_wr_gnt;
    logic [1:0]        w_rd_win;
    logic [1:0]        w_wr_win;
    logic [1:0]        w_gnt;
    logic              w_conflict;
    logic              w_rd_cont;
    logic              w_wr_cont;

    logic              r_prio;
    logic [1:0]        r_rsp_vld;
    logic [1:0]        r_rsp_err;
    logic [1:0]        r_rsp_rd;

    for (genvar g = 0; g < 2; g++) begin : g_dec
        assign w_req[g]    = '{we: m_we[g], addr: m_addr[g], wdata: m_wdata[g]};
        assign w_idx[g]    = w_req[g].addr[ADDR_W+1:2];
        assign w_legal[g]  = (w_req[g].addr[1:0] == 2'b00) &&
                             ({2'b00, w_req[g].addr[31:2]} < DEPTH_W);
        assign w_rd_req[g] = m_req[g] & w_legal[g] & ~w_req[g].we;
        assign w_wr_req[g] = m_req[g] & w_legal[g] &  w_req[g].we;
        assign m_rdata[g]  = (r_rsp_vld[g] & r_rsp_rd[g] & ~r_rsp_err[g]) ? ram_rdata : 32'h0;
    end

    // A read and a write to the same word from different masters must not share a cycle:
    // present the pair to both pickers so they resolve it like ordinary contention.
    assign w_conflict    = ((w_rd_req[0] & w_wr_req[1]) | (w_rd_req[1] & w_wr_req[0])) &
                           (w_idx[0] == w_idx[1]);
    assign w_rd_pick_req = w_rd_req | (w_conflict ? w_wr_req : 2'b00);
    assign w_wr_pick_req = w_wr_req | (w_conflict ? w_rd_req : 2'b00);

    rr_arb2 u_rd_arb (
        .req       (w_rd_pick_req),
        .prio      (r_prio),
        .gnt       (w_rd_gnt),
        .contended (w_rd_cont)
    );

    rr_arb2 u_wr_arb (
        .req       (w_wr_pick_req),
        .prio      (r_prio),
        .gnt       (w_wr_gnt),
        .contended (w_wr_cont)
    );

    assign w_rd_win = w_rd_gnt & w_rd_req;
    assign w_wr_win = w_wr_gnt & w_wr_req;
    assign w_gnt    = (w_rd_win | w_wr_win | (m_req & ~w_legal)) & {2{rst_n}};
    assign m_gnt    = w_gnt;

    assign ram_ren   = (|w_rd_win) & rst_n;
    assign ram_raddr = w_rd_win[M_LSU] ? w_idx[M_LSU] : w_idx[M_IFETCH];
    assign ram_wen   = (|w_wr_win) & rst_n;
    assign ram_waddr = w_wr_win[M_LSU] ? w_idx[M_LSU] : w_idx[M_IFETCH];
    assign ram_wdata = w_wr_win[M_LSU] ? w_req[M_LSU].wdata : w_req[M_IFETCH].wdata;

    // The winner always equals r_prio, so handing priority to the loser is a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_rd_cont | w_wr_cont) begin
            r_prio <= ~r_prio;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld <= 2'b00;
            r_rsp_err <= 2'b00;
            r_rsp_rd  <= 2'b00;
        end else begin
            r_rsp_vld <= w_gnt;
            r_rsp_err <= w_gnt & ~w_legal;
            r_rsp_rd  <= w_gnt & ~m_we;
        end
    end

    assign m_rvalid = r_rsp_vld & {2{rst_n}};
    assign m_err    = r_rsp_err & {2{rst_n}};

endmodule
